// File: rtl/cell_ctrl_pkg.sv
// cell_ctrl_pkg: board geometry, FSM state encoding and cursor helpers shared
// by the cell-selection controller.
package cell_ctrl_pkg;
    localparam int GRID_DIM = 8;
    localparam int CELLS    = 64;
    localparam int IDX_W    = 6;
    localparam int POS_W    = 3;
    localparam int BTN_W    = 5;

    localparam logic [POS_W-1:0] MAX_POS = POS_W'(GRID_DIM - 1);

    typedef enum logic [1:0] {
        ST_SELECT = 2'd0,
        ST_REQ    = 2'd1,
        ST_SWAP   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic sel;
    } btn_t;

    // One step toward the board edge, saturating instead of wrapping.
    function automatic logic [POS_W-1:0] sat_step(input logic [POS_W-1:0] pos, input logic inc);
        return inc ? ((pos == MAX_POS) ? pos : pos + 1'b1)
                   : ((pos == '0) ? pos : pos - 1'b1);
    endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: per-bit rising-edge detector; a level held high yields one pulse.
module btn_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] lvl_i,
    output logic [W-1:0] rise_o
);
    logic [W-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= lvl_i;
    end

    assign rise_o = lvl_i & ~prev_q;
endmodule

// File: rtl/cell_select_ctrl.sv
// cell_select_ctrl: cursor navigation, placement handshake and per-turn timing
// for a two-player 8x8 board game.
module cell_select_ctrl
    import cell_ctrl_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 500000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_sel,
    input  logic [CELLS-1:0] occupied,
    input  logic             game_over,
    input  logic             place_ack,
    output logic [POS_W-1:0] cursor_row,
    output logic [POS_W-1:0] cursor_col,
    output logic [IDX_W-1:0] cursor_idx,
    output logic [CELLS-1:0] cursor_oh,
    output logic             player,
    output logic             place_req,
    output logic [IDX_W-1:0] place_idx,
    output logic             place_player,
    output logic             reject,
    output logic             timeout
);
    state_t           state_q, state_d;
    logic [POS_W-1:0] row_q, row_d, col_q, col_d;
    logic             player_q, player_d;
    logic [31:0]      timer_q, timer_d;
    logic             req_q, req_d;
    logic [IDX_W-1:0] pidx_q, pidx_d;
    logic             pply_q, pply_d;
    logic             reject_q, reject_d;
    logic             timeout_q, timeout_d;
    btn_t             rise;
    logic             tmo;

    btn_edge #(.W(BTN_W)) u_btn_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .lvl_i ({btn_up, btn_down, btn_left, btn_right, btn_sel}),
        .rise_o(rise)
    );

    assign tmo = (timer_q == TURN_CYCLES - 32'd1);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        player_d  = player_q;
        timer_d   = timer_q;
        req_d     = req_q;
        pidx_d    = pidx_q;
        pply_d    = pply_q;
        reject_d  = 1'b0;
        timeout_d = 1'b0;
        if (game_over) begin
            state_d = ST_HALT;
            req_d   = 1'b0;
        end else begin
            case (state_q)
                ST_SELECT: begin
                    timer_d   = timer_q + 32'd1;
                    timeout_d = tmo;
                    state_d   = tmo ? ST_SWAP : ST_SELECT;
                    // Select outranks every direction; on the expiry cycle it is dropped.
                    if (rise.sel) begin
                        if (!tmo && occupied[cursor_idx]) begin
                            reject_d = 1'b1;
                        end else if (!tmo) begin
                            state_d = ST_REQ;
                            req_d   = 1'b1;
                            pidx_d  = cursor_idx;
                            pply_d  = player_q;
                        end
                    end else if (rise.up) begin
                        row_d = sat_step(row_q, 1'b0);
                    end else if (rise.down) begin
                        row_d = sat_step(row_q, 1'b1);
                    end else if (rise.left) begin
                        col_d = sat_step(col_q, 1'b0);
                    end else if (rise.right) begin
                        col_d = sat_step(col_q, 1'b1);
                    end
                end
                ST_REQ: begin
                    req_d   = place_ack ? 1'b0 : 1'b1;
                    state_d = place_ack ? ST_SWAP : ST_REQ;
                end
                ST_SWAP: begin
                    player_d = ~player_q;
                    timer_d  = '0;
                    state_d  = ST_SELECT;
                end
                default: begin
                    state_d  = ST_SELECT;
                    row_d    = '0;
                    col_d    = '0;
                    player_d = 1'b0;
                    timer_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SELECT;
            row_q     <= '0;
            col_q     <= '0;
            player_q  <= 1'b0;
            timer_q   <= '0;
            req_q     <= 1'b0;
            pidx_q    <= '0;
            pply_q    <= 1'b0;
            reject_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            player_q  <= player_d;
            timer_q   <= timer_d;
            req_q     <= req_d;
            pidx_q    <= pidx_d;
            pply_q    <= pply_d;
            reject_q  <= reject_d;
            timeout_q <= timeout_d;
        end
    end

    assign cursor_row   = row_q;
    assign cursor_col   = col_q;
    assign cursor_idx   = {row_q, col_q};
    assign cursor_oh    = {{(CELLS-1){1'b0}}, 1'b1} << cursor_idx;
    assign player       = player_q;
    assign place_req    = req_q;
    assign place_idx    = pidx_q;
    assign place_player = pply_q;
    assign reject       = reject_q;
    assign timeout      = timeout_q;
endmodule

// File: tb/tb_cell_select_ctrl.sv
// tb_cell_select_ctrl: directed vector table for cursor moves plus hand-written
// sequences for handshake, halt, reset and turn timeout.
module tb_cell_select_ctrl;
    localparam logic [4:0] B_U = 5'b10000;
    localparam logic [4:0] B_D = 5'b01000;
    localparam logic [4:0] B_L = 5'b00100;
    localparam logic [4:0] B_R = 5'b00010;
    localparam logic [4:0] B_S = 5'b00001;
    localparam logic [63:0] OCC26 = 64'h0000_0000_0400_0000;

    logic        clk, rst_n;
    logic        btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic [63:0] occupied;
    logic        game_over, place_ack;

    logic [2:0]  cursor_row, cursor_col, t_row, t_col;
    logic [5:0]  cursor_idx, place_idx, t_idx, t_pidx;
    logic [63:0] cursor_oh, t_oh;
    logic        player, place_req, place_player, reject, timeout;
    logic        t_player, t_req, t_pply, t_reject, t_timeout;

    int checks = 0;
    int failures = 0;

    cell_select_ctrl #(.TURN_CYCLES(1000)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right), .btn_sel(btn_sel),
        .occupied(occupied), .game_over(game_over), .place_ack(place_ack),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .cursor_idx(cursor_idx), .cursor_oh(cursor_oh),
        .player(player), .place_req(place_req), .place_idx(place_idx), .place_player(place_player),
        .reject(reject), .timeout(timeout)
    );

    cell_select_ctrl #(.TURN_CYCLES(16)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right), .btn_sel(btn_sel),
        .occupied(occupied), .game_over(game_over), .place_ack(place_ack),
        .cursor_row(t_row), .cursor_col(t_col), .cursor_idx(t_idx), .cursor_oh(t_oh),
        .player(t_player), .place_req(t_req), .place_idx(t_pidx), .place_player(t_pply),
        .reject(t_reject), .timeout(t_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  btn;
        logic [63:0] occ;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        rej;
    } vec_t;

    vec_t vt [26];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [4:0] b);
        {btn_up, btn_down, btn_left, btn_right, btn_sel} = b;
    endtask

    task automatic press(input logic [4:0] b);
        set_btn(b);
        step();
        set_btn(5'b0);
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_btn(5'b0);
        occupied  = '0;
        game_over = 1'b0;
        place_ack = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{B_S,       64'h1, 3'd0, 3'd0, 1'b1};
        vt[1]  = '{B_U,       64'h0, 3'd0, 3'd0, 1'b0};
        vt[2]  = '{B_U,       64'h0, 3'd0, 3'd0, 1'b0};
        vt[3]  = '{B_U,       64'h0, 3'd0, 3'd0, 1'b0};
        vt[4]  = '{B_R,       64'h0, 3'd0, 3'd1, 1'b0};
        vt[5]  = '{B_R,       64'h0, 3'd0, 3'd2, 1'b0};
        vt[6]  = '{B_R,       64'h0, 3'd0, 3'd3, 1'b0};
        vt[7]  = '{B_R,       64'h0, 3'd0, 3'd4, 1'b0};
        vt[8]  = '{B_R,       64'h0, 3'd0, 3'd5, 1'b0};
        vt[9]  = '{B_R,       64'h0, 3'd0, 3'd6, 1'b0};
        vt[10] = '{B_R,       64'h0, 3'd0, 3'd7, 1'b0};
        vt[11] = '{B_R,       64'h0, 3'd0, 3'd7, 1'b0};
        vt[12] = '{B_R,       64'h0, 3'd0, 3'd7, 1'b0};
        vt[13] = '{B_D,       64'h0, 3'd1, 3'd7, 1'b0};
        vt[14] = '{B_D,       64'h0, 3'd2, 3'd7, 1'b0};
        vt[15] = '{B_D,       64'h0, 3'd3, 3'd7, 1'b0};
        vt[16] = '{B_L,       64'h0, 3'd3, 3'd6, 1'b0};
        vt[17] = '{B_L,       64'h0, 3'd3, 3'd5, 1'b0};
        vt[18] = '{B_L,       64'h0, 3'd3, 3'd4, 1'b0};
        vt[19] = '{B_L,       64'h0, 3'd3, 3'd3, 1'b0};
        vt[20] = '{B_U | B_R, 64'h0, 3'd2, 3'd3, 1'b0};
        vt[21] = '{B_D | B_L, 64'h0, 3'd3, 3'd3, 1'b0};
        vt[22] = '{B_L | B_R, 64'h0, 3'd3, 3'd2, 1'b0};
        vt[23] = '{B_S,       OCC26, 3'd3, 3'd2, 1'b1};
        vt[24] = '{B_S | B_U, OCC26, 3'd3, 3'd2, 1'b1};
        vt[25] = '{B_D | B_R, 64'h0, 3'd4, 3'd2, 1'b0};

        do_reset();
        chk("rst_row", 64'(cursor_row), 64'(0));
        chk("rst_col", 64'(cursor_col), 64'(0));
        chk("rst_oh", cursor_oh, 64'h1);
        chk("rst_player", 64'(player), 64'(0));
        chk("rst_req", 64'(place_req), 64'(0));
        chk("rst_pidx", 64'(place_idx), 64'(0));
        chk("rst_rej", 64'(reject), 64'(0));
        chk("rst_tmo", 64'(timeout), 64'(0));

        for (int i = 0; i < 26; i++) begin
            occupied = vt[i].occ;
            set_btn(vt[i].btn);
            step();
            set_btn(5'b0);
            chk($sformatf("vec%0d_row", i), 64'(cursor_row), 64'(vt[i].row));
            chk($sformatf("vec%0d_col", i), 64'(cursor_col), 64'(vt[i].col));
            chk($sformatf("vec%0d_idx", i), 64'(cursor_idx), 64'({vt[i].row, vt[i].col}));
            chk($sformatf("vec%0d_oh", i), cursor_oh, 64'h1 << {vt[i].row, vt[i].col});
            chk($sformatf("vec%0d_rej", i), 64'(reject), 64'(vt[i].rej));
            chk($sformatf("vec%0d_req", i), 64'(place_req), 64'(0));
            chk($sformatf("vec%0d_player", i), 64'(player), 64'(0));
            step();
            chk($sformatf("vec%0d_rej_clr", i), 64'(reject), 64'(0));
        end

        // placement handshake on cell 10, ack after the fourth REQ cycle
        do_reset();
        press(B_D);
        press(B_R);
        press(B_R);
        chk("hs_cursor", 64'(cursor_idx), 64'(10));
        btn_sel = 1'b1;
        step();
        btn_sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hs_req%0d", i), 64'(place_req), 64'(1));
            chk($sformatf("hs_pidx%0d", i), 64'(place_idx), 64'(10));
            chk($sformatf("hs_pply%0d", i), 64'(place_player), 64'(0));
            chk($sformatf("hs_hold_cur%0d", i), 64'(cursor_idx), 64'(10));
            btn_up    = (i == 1);
            btn_sel   = (i == 2);
            place_ack = (i == 4);
            step();
        end
        set_btn(5'b0);
        place_ack = 1'b0;
        chk("hs_req_drop", 64'(place_req), 64'(0));
        chk("hs_player_swap_cycle", 64'(player), 64'(0));
        step();
        chk("hs_player_new", 64'(player), 64'(1));
        chk("hs_cursor_kept", 64'(cursor_idx), 64'(10));
        place_ack = 1'b1;
        step();
        step();
        place_ack = 1'b0;
        chk("ack_outside_req", 64'(place_req), 64'(0));
        chk("ack_outside_player", 64'(player), 64'(1));

        // game_over during REQ, then async reset during REQ
        do_reset();
        btn_sel = 1'b1;
        step();
        btn_sel = 1'b0;
        place_ack = 1'b1;
        step();
        place_ack = 1'b0;
        step();
        chk("go_player1", 64'(player), 64'(1));
        press(B_D);
        press(B_R);
        btn_sel = 1'b1;
        step();
        btn_sel = 1'b0;
        chk("go_req", 64'(place_req), 64'(1));
        chk("go_pidx", 64'(place_idx), 64'(9));
        chk("go_pply", 64'(place_player), 64'(1));
        game_over = 1'b1;
        step();
        chk("go_req_drop", 64'(place_req), 64'(0));
        btn_down = 1'b1;
        step();
        btn_down = 1'b0;
        step();
        chk("halt_cursor_frozen", 64'(cursor_idx), 64'(9));
        game_over = 1'b0;
        step();
        chk("halt_rel_cursor", 64'(cursor_idx), 64'(0));
        chk("halt_rel_player", 64'(player), 64'(0));
        chk("halt_rel_req", 64'(place_req), 64'(0));
        press(B_R);
        btn_sel = 1'b1;
        step();
        btn_sel = 1'b0;
        chk("ar_req", 64'(place_req), 64'(1));
        chk("ar_pidx", 64'(place_idx), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req_clr", 64'(place_req), 64'(0));
        chk("ar_pidx_clr", 64'(place_idx), 64'(0));
        chk("ar_cursor_clr", 64'(cursor_idx), 64'(0));
        chk("ar_oh", cursor_oh, 64'h1);
        chk("ar_player", 64'(player), 64'(0));

        // button held through reset yields one edge after release, then no repeat
        btn_right = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk("held_rst_edge", 64'(cursor_col), 64'(1));
        step();
        step();
        chk("held_no_repeat", 64'(cursor_col), 64'(1));
        btn_right = 1'b0;

        // turn timeout with TURN_CYCLES=16: pulses after edges 16, 33, 50
        do_reset();
        for (int k = 1; k <= 55; k++) begin
            step();
            chk($sformatf("tmo_c%0d", k), 64'(t_timeout), 64'((k == 16) || (k == 33) || (k == 50)));
            chk($sformatf("tmo_player_c%0d", k), 64'(t_player),
                64'(((k >= 17) && (k < 34)) || (k >= 51)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cell_select_ctrl.md
CELL_SELECT_CTRL -- requirements
Module: cell_select_ctrl

Interface
REQ-001 Parameter TURN_CYCLES, default 500000000, is the per-turn time limit in clk cycles (10 s at 50 MHz); legal range is 2..2^32-1.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 btn_up, btn_down, btn_left, btn_right, btn_sel  input  1 each  already-synchronized, debounced, active-high button levels.
REQ-005 occupied  input  64  board occupancy; bit i = row*8+col is set when cell i holds a piece.
REQ-006 game_over  input  1  level from game logic; high halts play.
REQ-007 place_ack  input  1  game logic accepts the pending placement.
REQ-008 cursor_row, cursor_col  output  3 each  current cursor cell.
REQ-009 cursor_idx  output  6  row*8+col.
REQ-010 cursor_oh  output  64  one-hot of cursor_idx, used for highlight gating against the pixel cell-hit vector.
REQ-011 player  output  1  player whose turn it is (0/1).
REQ-012 place_req, place_idx[5:0], place_player  output  1/6/1  placement request and its payload.
REQ-013 reject, timeout  output  1 each  single-cycle pulses.

Function
REQ-014 The block SHALL detect a rising edge on each button; only edges act, so held levels cause no repeat.
REQ-015 The FSM SHALL have the states SELECT, REQ, SWAP and HALT.
REQ-016 In SELECT, a direction edge SHALL move the cursor one cell on the next cycle and saturate at the board edge, with no wrap-around.
REQ-017 When several direction edges occur in the same cycle, only one SHALL be applied, with priority up > down > left > right.
REQ-018 In SELECT, a btn_sel edge with occupied[cursor_idx]=0 SHALL move the FSM to REQ and latch place_idx=cursor_idx and place_player=player.
REQ-019 In SELECT, a btn_sel edge with occupied[cursor_idx]=1 SHALL pulse reject for one cycle and keep the FSM in SELECT.
REQ-020 A btn_sel edge and a direction edge in the same cycle SHALL give btn_sel priority, and the cursor SHALL not move.
REQ-021 In REQ, place_req SHALL be held high with a stable payload until place_ack is sampled high; the FSM then SHALL enter SWAP.
REQ-022 In REQ, all button inputs SHALL be ignored; a place_ack seen outside REQ SHALL be ignored.
REQ-023 The turn timer SHALL increment in SELECT only and freeze in REQ.
REQ-024 When the turn timer reaches TURN_CYCLES-1 in SELECT, the block SHALL pulse timeout and enter SWAP, and a btn_sel edge in that same cycle SHALL be discarded.
REQ-025 SWAP SHALL last one cycle: player toggles, the timer clears, the cursor is retained, and the FSM returns to SELECT.
REQ-026 game_over high in any state SHALL force HALT on the next cycle; place_req SHALL drop in the same cycle HALT is entered, and the pending request is abandoned.
REQ-027 HALT SHALL ignore buttons and freeze the timer; on game_over low the block SHALL clear cursor, player and timer to 0 and enter SELECT.
REQ-028 cursor_idx and cursor_oh SHALL be combinational decodes of the registered cursor, giving zero added latency.

Reset
REQ-029 Asserting rst_n low SHALL immediately force the following, mid-operation included:
- state SELECT, with cursor_row, cursor_col, player and timer at 0;
- place_req, place_idx, place_player, reject and timeout at 0;
- the previous-button edge registers at 0, so a button held through reset produces an edge on the first cycle after release.

Structure
REQ-030 Package cell_ctrl_pkg SHALL hold the state enum, GRID_DIM=8, CELLS=64 and the index width 6.
REQ-031 Sub-module btn_edge SHALL implement a parameterized-width rising-edge detector with clk and rst_n, instantiated once with width 5.

Verification
REQ-032 Move and saturation: from reset, 3 up edges then 9 right edges -> row 0, col 7, cursor_idx 7, cursor_oh = 64'h80.
REQ-033 Priority: up and right edges in the same cycle at (3,3) -> cursor at (2,3).
REQ-034 Place handshake: sel on free cell 10, ack after 4 cycles -> place_req high for exactly 5 cycles with place_idx 10 and place_player 0; player becomes 1 two cycles after ack.
REQ-035 Reject: occupied[0]=1, sel at (0,0) -> one-cycle reject, no place_req, player unchanged.
REQ-036 Timeout: TURN_CYCLES=16, no input -> timeout pulses on cycle 16 of SELECT, player toggles, then repeats every 17 cycles.
REQ-037 Halt and reset mid-operation:
- game_over during REQ -> place_req low on the next cycle; on release, cursor 0 and player 0;
- rst_n low during REQ -> all outputs 0 asynchronously.
